// File: rtl/str_pack_pkg.sv
// ---------------------------------------------------------------------------
// str_pack_pkg
// Shared types and constants for the 24-bit to 32-bit sample packer.
//   state_t   : packer FSM state (RUN while accepting samples, FLUSH while
//               emitting the zero-padded tail word of a frame)
//   phase_t   : number of residual bytes held between samples (0..3)
//   KEEP_*    : byte-valid masks for full and partial output words
//   flush_keep: maps a residual byte count to its tail-word tkeep
// ---------------------------------------------------------------------------
package str_pack_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef logic [1:0] phase_t;

  localparam logic [3:0] KEEP_FULL = 4'b1111;
  localparam logic [3:0] KEEP_3B   = 4'b0111;
  localparam logic [3:0] KEEP_2B   = 4'b0011;
  localparam logic [3:0] KEEP_1B   = 4'b0001;

  // Byte mask for the tail word built from 'p' residual bytes.
  function automatic logic [3:0] flush_keep(input phase_t p);
    logic [3:0] k;
    case (p)
      2'd3:    k = KEEP_3B;
      2'd2:    k = KEEP_2B;
      2'd1:    k = KEEP_1B;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/str_axis_out_reg.sv
// ---------------------------------------------------------------------------
// str_axis_out_reg
// One-stage AXI-stream holding register. When 'load' is high the word on
// in_* is captured and presented as valid; otherwise the held word stays
// stable until the consumer accepts it, after which tvalid drops.
// The caller only asserts 'load' when the register is empty or draining
// (!m_axis_tvalid || m_axis_tready).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   load               : capture in_data/in_keep/in_last this cycle
//   in_data/keep/last  : word to capture
//   m_axis_tready      : downstream ready
//   m_axis_tdata/tkeep/tlast/tvalid : registered stream outputs
// ---------------------------------------------------------------------------
module str_axis_out_reg #(
  parameter int OW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [OW-1:0]   in_data,
  input  logic [OW/8-1:0] in_keep,
  input  logic            in_last,
  input  logic            m_axis_tready,
  output logic [OW-1:0]   m_axis_tdata,
  output logic [OW/8-1:0] m_axis_tkeep,
  output logic            m_axis_tlast,
  output logic            m_axis_tvalid
);

  logic [OW-1:0]   tdata_q,  tdata_d;
  logic [OW/8-1:0] tkeep_q,  tkeep_d;
  logic            tlast_q,  tlast_d;
  logic            tvalid_q, tvalid_d;

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = in_data;
      tkeep_d  = in_keep;
      tlast_d  = in_last;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: rtl/str_sample_packer.sv
// ---------------------------------------------------------------------------
// str_sample_packer
// Packs a stream of 24-bit samples into dense little-endian 32-bit words
// (four samples -> three words). A frame ending mid-word produces a
// zero-padded tail word with a partial tkeep and tlast set; a frame ending
// on a word boundary marks its final full word with tlast directly.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready : 24-bit sample input stream
//   m_axis_tdata/tkeep/tlast/tvalid/tready : 32-bit packed output stream
//   frame_cnt                : count of frames whose last word was loaded
// ---------------------------------------------------------------------------
module str_sample_packer
  import str_pack_pkg::*;
#(
  parameter int DW = 24,
  parameter int OW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  output logic            s_axis_tready,
  output logic [OW-1:0]   m_axis_tdata,
  output logic [OW/8-1:0] m_axis_tkeep,
  output logic            m_axis_tlast,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic [CW-1:0]   frame_cnt
);

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [DW-1:0] res_q, res_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  logic            can_load;
  logic            accept;
  logic            word_vld;
  logic [OW-1:0]   word_data;
  logic [OW/8-1:0] word_keep;
  logic            word_last;

  always_comb begin
    can_load      = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = (state_q == RUN) && can_load;
    accept        = s_axis_tvalid && s_axis_tready;

    state_d   = state_q;
    phase_d   = phase_q;
    res_d     = res_q;
    word_vld  = 1'b0;
    word_data = '0;
    word_keep = KEEP_FULL;
    word_last = 1'b0;

    if (state_q == FLUSH) begin
      // Tail word: residual bytes in the low lanes, upper lanes zero.
      if (can_load) begin
        word_vld  = 1'b1;
        word_last = 1'b1;
        word_keep = flush_keep(phase_q);
        case (phase_q)
          2'd3:    word_data = {8'h00, res_q[23:0]};
          2'd2:    word_data = {16'h0000, res_q[15:0]};
          2'd1:    word_data = {24'h000000, res_q[7:0]};
          default: word_data = '0;
        endcase
        phase_d = 2'd0;
        res_d   = '0;
        state_d = RUN;
      end
    end else if (accept) begin
      case (phase_q)
        2'd0: begin
          res_d   = s_axis_tdata;
          phase_d = 2'd3;
        end
        2'd3: begin
          word_data = {s_axis_tdata[7:0], res_q[23:0]};
          res_d     = {8'h00, s_axis_tdata[23:8]};
          phase_d   = 2'd2;
        end
        2'd2: begin
          word_data = {s_axis_tdata[15:0], res_q[15:0]};
          res_d     = {16'h0000, s_axis_tdata[23:16]};
          phase_d   = 2'd1;
        end
        default: begin
          word_data = {s_axis_tdata[23:0], res_q[7:0]};
          res_d     = '0;
          phase_d   = 2'd0;
        end
      endcase
      word_vld = (phase_q != 2'd0);
      // Only a sample entering at phase 1 empties the residual; any other
      // frame end leaves bytes behind that need a tail word.
      if (s_axis_tlast) begin
        if (phase_q == 2'd1) begin
          word_last = 1'b1;
        end else begin
          state_d = FLUSH;
        end
      end
    end

    // A word is only ever offered when the output register can take it,
    // so word_vld doubles as the register load strobe.
    frame_cnt_d = frame_cnt_q;
    if (word_vld && word_last) begin
      frame_cnt_d = frame_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      phase_q     <= 2'd0;
      res_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      res_q       <= res_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

  str_axis_out_reg #(
    .OW(OW)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (word_vld),
    .in_data       (word_data),
    .in_keep       (word_keep),
    .in_last       (word_last),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid)
  );

endmodule

// File: tb/tb_str_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_str_sample_packer
// Self-checking bench for str_sample_packer. A byte-queue reference model
// turns every accepted sample into expected 32-bit words; a monitor records
// every output handshake, counts s_axis_tready-low cycles and flags any
// change of the output word while it is stalled.
// ---------------------------------------------------------------------------
module tb_str_sample_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  str_sample_packer #(.DW(24), .OW(32), .CW(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt)
  );

  int checks     = 0;
  int failures   = 0;
  int stall_viol = 0;
  int trdy_low   = 0;
  int exp_frames = 0;
  bit bp_en      = 1'b0;

  word_t       exp_q[$];
  word_t       rcv_q[$];
  logic [7:0]  mb[$];

  // Reference model: the frame is just a byte string cut into 4-byte words.
  function automatic void model_push(input logic [23:0] d, input logic last);
    word_t w;
    mb.push_back(d[7:0]);
    mb.push_back(d[15:8]);
    mb.push_back(d[23:16]);
    while (mb.size() >= 4) begin
      w.d = {mb[3], mb[2], mb[1], mb[0]};
      w.k = 4'hF;
      repeat (4) void'(mb.pop_front());
      w.l = last && (mb.size() == 0);
      exp_q.push_back(w);
    end
    if (last) begin
      if (mb.size() > 0) begin
        w.d = '0;
        w.k = '0;
        for (int i = 0; i < mb.size(); i++) begin
          w.d[8*i +: 8] = mb[i];
          w.k[i]        = 1'b1;
        end
        w.l = 1'b1;
        exp_q.push_back(w);
        mb.delete();
      end
      exp_frames++;
    end
  endfunction

  // Downstream ready: always high unless backpressure is enabled.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    word_t cur;
    word_t prev_w;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!m_axis_tvalid || cur != prev_w)) stall_viol++;
        if (!s_axis_tready) trdy_low++;
        if (m_axis_tvalid && m_axis_tready) rcv_q.push_back(cur);
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_w     = cur;
      end
    end
  end

  task automatic do_reset();
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    rcv_q.delete();
    mb.delete();
    exp_frames = 0;
    stall_viol = 0;
    trdy_low   = 0;
  endtask

  // Present one sample and hold it until the DUT accepts it.
  task automatic send_sample(input logic [23:0] d, input logic last);
    bit acc;
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (acc) begin
      model_push(d, last);
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: sample %h not accepted in %0d cycles, want accepted", d, n);
    end
  endtask

  // mode 0: random samples, mode 1: counting pattern.
  task automatic send_frame(input int n, input int mode, input bit last);
    for (int i = 0; i < n; i++) begin
      send_sample(mode == 1 ? 24'(i) : 24'($urandom), last && (i == n - 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(output bit timed_out);
    int n;
    n = 0;
    while ((rcv_q.size() < exp_q.size() || m_axis_tvalid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    timed_out = (n >= 5000);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready: got %b, want 1", s_axis_tready);
    end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h, want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_frame_cnt: got %0d, want 0", frame_cnt);
    end
  endtask

  task automatic test_basic();
    bit          to;
    logic [31:0] lit [3];
    lit[0] = 32'h04030201;
    lit[1] = 32'h08070605;
    lit[2] = 32'h0C0B0A09;
    do_reset();
    send_sample(24'h030201, 1'b0);
    send_sample(24'h060504, 1'b0);
    send_sample(24'h090807, 1'b0);
    send_sample(24'h0C0B0A, 1'b0);
    s_axis_tvalid = 1'b0;
    wait_drain(to);
    checks++;
    if (to || rcv_q.size() != 3) begin
      failures++;
      $display("FAIL basic_count: got %0d words, want 3", rcv_q.size());
    end
    for (int i = 0; i < 3 && i < rcv_q.size(); i++) begin
      checks++;
      if (rcv_q[i] !== '{d: lit[i], k: 4'hF, l: 1'b0}) begin
        failures++;
        $display("FAIL basic_word%0d: got d=%h k=%h l=%b, want d=%h k=f l=0",
                 i, rcv_q[i].d, rcv_q[i].k, rcv_q[i].l, lit[i]);
      end
    end
  endtask

  task automatic test_long_frame();
    bit to;
    do_reset();
    send_frame(16000, 1, 1'b1);
    wait_drain(to);
    checks++;
    if (to || rcv_q.size() != 12000) begin
      failures++;
      $display("FAIL long_count: got %0d words, want 12000", rcv_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      checks++;
      if (rcv_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL long_word%0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b", i,
                 rcv_q[i].d, rcv_q[i].k, rcv_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
        break;
      end
    end
    if (rcv_q.size() == 12000) begin
      checks++;
      if (rcv_q[11999].l !== 1'b1 || rcv_q[11999].k !== 4'hF) begin
        failures++;
        $display("FAIL long_last: got k=%h l=%b, want k=f l=1", rcv_q[11999].k, rcv_q[11999].l);
      end
    end
    checks++;
    if (trdy_low != 0) begin
      failures++;
      $display("FAIL long_no_flush: got %0d tready-low cycles, want 0", trdy_low);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL long_frame_cnt: got %0d, want 1", frame_cnt);
    end
  endtask

  task automatic test_flush_tails();
    bit to;
    int lens [3];
    logic [3:0] keeps [3];
    lens[0] = 5; keeps[0] = 4'h7;
    lens[1] = 2; keeps[1] = 4'h3;
    lens[2] = 3; keeps[2] = 4'h1;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      exp_q.delete();
      rcv_q.delete();
      trdy_low = 0;
      send_frame(lens[f], 0, 1'b1);
      wait_drain(to);
      checks++;
      if (to || rcv_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL tail%0d_count: got %0d words, want %0d", lens[f], rcv_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
        checks++;
        if (rcv_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL tail%0d_word%0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b", lens[f], i,
                   rcv_q[i].d, rcv_q[i].k, rcv_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
        end
      end
      if (rcv_q.size() > 0) begin
        checks++;
        if (rcv_q[rcv_q.size()-1].k !== keeps[f] || rcv_q[rcv_q.size()-1].l !== 1'b1) begin
          failures++;
          $display("FAIL tail%0d_keep: got k=%h l=%b, want k=%h l=1", lens[f],
                   rcv_q[rcv_q.size()-1].k, rcv_q[rcv_q.size()-1].l, keeps[f]);
        end
      end
      checks++;
      if (trdy_low != 1) begin
        failures++;
        $display("FAIL tail%0d_flush_cycles: got %0d tready-low cycles, want 1", lens[f], trdy_low);
      end
      checks++;
      if (frame_cnt !== 16'(f + 1)) begin
        failures++;
        $display("FAIL tail%0d_frame_cnt: got %0d, want %0d", lens[f], frame_cnt, f + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(int'($urandom_range(1, 30)), 0, 1'b1);
    end
    wait_drain(to);
    bp_en = 1'b0;
    checks++;
    if (to || rcv_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count: got %0d words, want %0d", rcv_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      checks++;
      if (rcv_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_word%0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b", i,
                 rcv_q[i].d, rcv_q[i].k, rcv_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
        break;
      end
    end
    checks++;
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL bp_stable: got %0d changes while stalled, want 0", stall_viol);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL bp_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    do_reset();
    send_sample(24'hA3A2A1, 1'b0);
    send_sample(24'hB3B2B1, 1'b0);
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mb.delete();
    exp_frames = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, frame_cnt} !== 54'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got v=%b l=%b k=%h d=%h cnt=%0d, want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, frame_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_tready: got %b, want 1", s_axis_tready);
    end
    send_frame(4, 0, 1'b0);
    wait_drain(to);
    checks++;
    if (to || rcv_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midrst_count: got %0d words, want %0d", rcv_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      checks++;
      if (rcv_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midrst_word%0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b", i,
                 rcv_q[i].d, rcv_q[i].k, rcv_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midrst_frame_cnt: got %0d, want 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_frame();
    test_flush_tails();
    test_backpressure();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
